// File: rtl/imem_boot_loader.sv
// Purpose : UART-framed boot loader; writes 32-bit words into instruction memory and gates core reset.
// Latency : one imem write pulse the cycle after the 4th byte of each word; status flags update on the edge that consumes a byte.
// Backpressure: none; rx is a strobe-only stream, each byte is consumed in the cycle it is offered.
//
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   rx_data/rx_valid    : received byte with single-cycle strobe
//   load_req            : stop the core and wait for a new frame (wins over a coincident byte)
//   imem_we/addr/din    : instruction memory write port
//   core_rst_n          : active-low reset to the pipeline core
//   busy/done/err       : frame in progress / last frame loaded / error latched
//   err_code            : 0 none, 1 bad length, 2 checksum, 3 timeout
//   word_cnt            : words written in the current frame
module imem_boot_loader #(
    parameter int ADDR_W    = 8,
    parameter int TIMEOUT   = 100000,
    parameter bit BOOT_HOLD = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    input  logic              load_req,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_din,
    output logic              core_rst_n,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code,
    output logic [ADDR_W:0]   word_cnt
);
    localparam int               TMO_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
    localparam logic [16:0]      LEN_MAX  = 17'(2 ** ADDR_W);
    localparam logic [7:0]       SYNC     = 8'hA5;
    localparam logic [1:0]       ERR_LEN  = 2'd1;
    localparam logic [1:0]       ERR_CSUM = 2'd2;
    localparam logic [1:0]       ERR_TMO  = 2'd3;

    typedef enum logic [2:0] {
        S_HOLD,
        S_LEN_HI,
        S_LEN_LO,
        S_DATA,
        S_CSUM,
        S_RUN,
        S_ERROR
    } state_t;

    state_t            state_q;
    logic [7:0]        len_hi_q;
    logic [ADDR_W:0]   len_q;
    logic [23:0]       asm_q;        // first three bytes of the word being assembled
    logic [1:0]        byte_idx_q;
    logic [7:0]        csum_q;
    logic [TMO_W-1:0]  tmo_q;
    logic [ADDR_W:0]   word_cnt_q;   // doubles as the write word index
    logic              imem_we_q;
    logic [ADDR_W-1:0] imem_addr_q;
    logic [31:0]       imem_din_q;
    logic              core_rst_n_q;
    logic              busy_q;
    logic              done_q;
    logic              err_q;
    logic [1:0]        err_code_q;

    logic [15:0]     len_d;
    logic            len_bad_d;
    logic [31:0]     word_d;
    logic [ADDR_W:0] word_cnt_d;
    logic [7:0]      csum_d;
    logic            in_frame;

    assign len_d      = {len_hi_q, rx_data};
    // Widened by one bit so a LEN of exactly 2**ADDR_W is still accepted.
    assign len_bad_d  = (len_d == 16'd0) || ({1'b0, len_d} > LEN_MAX);
    assign word_d     = {asm_q, rx_data};
    assign word_cnt_d = word_cnt_q + (ADDR_W+1)'(1);
    assign csum_d     = csum_q ^ rx_data;
    assign in_frame   = (state_q == S_LEN_HI) || (state_q == S_LEN_LO) ||
                        (state_q == S_DATA)   || (state_q == S_CSUM);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if (BOOT_HOLD) state_q <= S_HOLD;
            else           state_q <= S_RUN;
            len_hi_q     <= '0;
            len_q        <= '0;
            asm_q        <= '0;
            byte_idx_q   <= '0;
            csum_q       <= '0;
            tmo_q        <= '0;
            word_cnt_q   <= '0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_din_q   <= '0;
            core_rst_n_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            err_code_q   <= '0;
        end else begin
            // Write strobe is a one-cycle pulse unless re-armed below.
            imem_we_q <= 1'b0;

            if (load_req) begin
                // Any in-flight byte this cycle is deliberately dropped.
                state_q      <= S_HOLD;
                core_rst_n_q <= 1'b0;
                busy_q       <= 1'b0;
                done_q       <= 1'b0;
                err_q        <= 1'b0;
                err_code_q   <= '0;
                word_cnt_q   <= '0;
                tmo_q        <= '0;
            end else if (in_frame) begin
                if (rx_valid) begin
                    tmo_q <= '0;
                    case (state_q)
                        S_LEN_HI: begin
                            len_hi_q <= rx_data;
                            csum_q   <= csum_d;
                            state_q  <= S_LEN_LO;
                        end
                        S_LEN_LO: begin
                            csum_q <= csum_d;
                            if (len_bad_d) begin
                                state_q    <= S_ERROR;
                                busy_q     <= 1'b0;
                                err_q      <= 1'b1;
                                err_code_q <= ERR_LEN;
                            end else begin
                                len_q      <= len_d[ADDR_W:0];
                                word_cnt_q <= '0;
                                byte_idx_q <= '0;
                                state_q    <= S_DATA;
                            end
                        end
                        S_DATA: begin
                            csum_q     <= csum_d;
                            asm_q      <= word_d[23:0];
                            byte_idx_q <= byte_idx_q + 2'd1;
                            if (byte_idx_q == 2'd3) begin
                                imem_we_q   <= 1'b1;
                                imem_addr_q <= word_cnt_q[ADDR_W-1:0];
                                imem_din_q  <= word_d;
                                word_cnt_q  <= word_cnt_d;
                                if (word_cnt_d == len_q) begin
                                    state_q <= S_CSUM;
                                end
                            end
                        end
                        S_CSUM: begin
                            busy_q <= 1'b0;
                            if (rx_data == csum_q) begin
                                state_q      <= S_RUN;
                                done_q       <= 1'b1;
                                core_rst_n_q <= 1'b1;
                            end else begin
                                state_q    <= S_ERROR;
                                err_q      <= 1'b1;
                                err_code_q <= ERR_CSUM;
                            end
                        end
                        default: state_q <= S_HOLD;
                    endcase
                end else if (tmo_q == TMO_LAST) begin
                    // Partial word in asm_q is discarded; nothing is written.
                    state_q    <= S_ERROR;
                    busy_q     <= 1'b0;
                    err_q      <= 1'b1;
                    err_code_q <= ERR_TMO;
                end else begin
                    tmo_q <= tmo_q + TMO_W'(1);
                end
            end else begin
                case (state_q)
                    S_HOLD: begin
                        core_rst_n_q <= 1'b0;
                        if (rx_valid && (rx_data == SYNC)) begin
                            state_q <= S_LEN_HI;
                            busy_q  <= 1'b1;
                            csum_q  <= '0;
                            tmo_q   <= '0;
                        end
                    end
                    // Covers the BOOT_HOLD=0 start: release on the first edge.
                    S_RUN:   core_rst_n_q <= 1'b1;
                    S_ERROR: core_rst_n_q <= 1'b0;
                    default: state_q      <= S_HOLD;
                endcase
            end
        end
    end

    assign imem_we    = imem_we_q;
    assign imem_addr  = imem_addr_q;
    assign imem_din   = imem_din_q;
    assign core_rst_n = core_rst_n_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;
    assign err_code   = err_code_q;
    assign word_cnt   = word_cnt_q;

endmodule

// File: doc/imem_boot_loader.md
Name: imem_boot_loader

Overview:
- Sits upstream of the five-stage pipeline core.
- Receives a framed byte stream from the board UART receiver and writes 32-bit instruction words into instruction memory through its write port.
- Holds the core in reset while loading, and releases it only after a complete, checksum-valid image has been written.
- Lets a new program be loaded without re-synthesising the memory initialisation file.

Parameters:
- ADDR_W, 8: instruction memory word-address width; max image = 2**ADDR_W words.
- TIMEOUT, 100000: idle clock cycles allowed between bytes inside a frame before abort.
- BOOT_HOLD, 1: 1 = after reset, hold core and wait for a frame; 0 = after reset, run the core from existing memory contents.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- rx_data  input  8  received byte, valid when rx_valid = 1.
- rx_valid  input  1  single-cycle strobe per received byte.
- load_req  input  1  single-cycle request to stop the core and accept a new frame.
- imem_we  output  1  instruction memory write enable.
- imem_addr  output  ADDR_W  instruction memory word address.
- imem_din  output  32  instruction memory write data.
- core_rst_n  output  1  active-low reset to the pipeline core.
- busy  output  1  high while in states LEN_HI, LEN_LO, DATA or CSUM.
- done  output  1  high once the last frame loaded successfully; cleared on load_req.
- err  output  1  high in state ERROR.
- err_code  output  2  0 none, 1 bad length, 2 checksum, 3 timeout.
- word_cnt  output  ADDR_W+1  words written in the current frame.

Behaviour:
- Frame format: 0xA5 sync, LEN_HI, LEN_LO (word count, big-endian), LEN x 4 data bytes (each word big-endian, MSB byte first), CSUM.
- CSUM = XOR of LEN_HI, LEN_LO and all data bytes.
- All outputs are registered.
- Reset values: imem_we 0, imem_addr 0, imem_din 0, core_rst_n 0, done 0, err 0, err_code 0, word_cnt 0.
- Reset state: HOLD if BOOT_HOLD = 1, else RUN. core_rst_n rises on the first clock edge after reset release when entering RUN.
- States and transitions:
  - HOLD: core_rst_n = 0. rx byte 0xA5 -> LEN_HI; any other byte is ignored.
  - LEN_HI: capture high length byte -> LEN_LO.
  - LEN_LO: form LEN. If LEN = 0 or LEN > 2**ADDR_W -> ERROR, code 1. Otherwise clear word index and byte index -> DATA.
  - DATA: shift each byte into the word assembly register. On the 4th byte of a word, assert imem_we for exactly the following cycle, with imem_addr = word index and imem_din = assembled word. Then word index +1 and word_cnt +1. After the write of word LEN-1 -> CSUM.
  - CSUM: received byte equals the running XOR -> RUN with done = 1; otherwise -> ERROR, code 2.
  - RUN: core_rst_n = 1. rx bytes are ignored.
  - ERROR: core_rst_n = 0, err = 1. Leaves only on load_req.
- load_req in any state: core_rst_n = 0 on the next edge; clear done, err, err_code, word_cnt; go to HOLD.
- load_req and rx_valid in the same cycle: load_req wins and the byte is dropped.
- Timeout counter:
  - Runs in LEN_HI, LEN_LO, DATA and CSUM.
  - Clears on every rx_valid and on state entry.
  - Reaching TIMEOUT-1 -> ERROR, code 3. No partial-word write is issued.
- Write address: word index is ADDR_W+1 bits wide; imem_addr carries its low ADDR_W bits. A maximal LEN of 2**ADDR_W writes addresses 0 .. 2**ADDR_W-1 with no wrap into address 0.
- Words already written before an error stay in memory. Only core release is withheld.
- Async reset mid-frame: imem_we drops immediately, the frame is abandoned, and the FSM goes to the reset state.

Test Plan:
- Good frame, BOOT_HOLD = 1: A5 00 02 12 34 56 78 9A BC DE F0 02 -> two write pulses, addr0 = 0x12345678, addr1 = 0x9ABCDEF0. Then core_rst_n = 1, done = 1, word_cnt = 2, err = 0.
- Same frame with CSUM 0x03 -> both writes occur, then ERROR: err_code = 2, core_rst_n = 0, done = 0. A following load_req -> HOLD, err = 0.
- LEN = 0x0000 -> err_code = 1, no writes. LEN = 0x0101 (ADDR_W = 8) -> err_code = 1. LEN = 0x0100 with 1024 data bytes -> last write at addr 0xFF, done = 1.
- TIMEOUT = 16: send A5 00 01 AA BB, then stop -> ERROR, err_code = 3, exactly 16 cycles after the BB strobe; imem_we never asserted.
- In RUN: load_req -> core_rst_n = 0 next cycle, done = 0. Bytes 55 00 are ignored, then a valid frame reloads. load_req coincident with an rx_valid byte drops that byte.
- Assert rst_n = 0 mid-DATA -> imem_we = 0 immediately, no further writes. With BOOT_HOLD = 0 after release: core_rst_n = 1 one cycle later, done = 0.
